// File: rtl/mem_param.sv
// -----------------------------------------------------------------------------
// mem_param: parameterised single-clock memory with per-entry valid tracking.
//
// Writes land in one cycle. Reads return one cycle later through a registered
// read_data with a read_valid pulse. Reads of entries that were never written
// (or addresses at/above DEPTH) return zero with a read_err pulse.
// used_count tracks how many distinct entries have been written since reset.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : address width in bits
//   DEPTH      : number of entries, 2 .. 2**ADDR_WIDTH
//   BYPASS     : 1 = same-address read returns the word being written this
//                cycle; 0 = it returns the word stored before the write
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-high reset (wins over read_rq/write_rq)
//   read_rq    : read request for r_address
//   write_rq   : write request of write_data to w_address
//   w_address  : write address
//   r_address  : read address
//   write_data : write word
//   read_data  : registered read word, holds between reads
//   read_valid : one-cycle pulse, read_data updated
//   read_err   : one-cycle pulse, read hit an unwritten/out-of-range entry
//   used_count : distinct entries written since reset
//   full       : used_count == DEPTH (informational, never blocks writes)
//
// Handshake: read_rq/write_rq are accepted on every rising edge where rst is
// low; there is no back-pressure. A read accepted at edge N is answered by
// read_valid high for exactly the cycle following edge N.
// -----------------------------------------------------------------------------
module mem_param #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_rq,
  input  logic                  write_rq,
  input  logic [ADDR_WIDTH-1:0] w_address,
  input  logic [ADDR_WIDTH-1:0] r_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  read_err,
  output logic [ADDR_WIDTH:0]   used_count,
  output logic                  full
);

  localparam int                DEPTH_I = DEPTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH_I[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  logic w_in_range;
  logic r_in_range;
  logic w_do;
  logic same_addr;

  // Addresses are widened by one bit so the compare also works when
  // DEPTH == 2**ADDR_WIDTH.
  assign w_in_range = {1'b0, w_address} < DEPTH_L;
  assign r_in_range = {1'b0, r_address} < DEPTH_L;
  assign w_do       = write_rq && w_in_range;
  assign same_addr  = w_do && r_in_range && (w_address == r_address);

  assign full = (used_count == DEPTH_L);

  // Storage array has no reset; stale contents are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (!rst && w_do) begin
      mem[w_address] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      read_err   <= 1'b0;
      used_count <= '0;
    end else begin
      read_valid <= read_rq;
      read_err   <= 1'b0;

      if (w_do) begin
        valid[w_address] <= 1'b1;
        // Only a first write to an entry grows the occupancy; since each
        // entry counts once, used_count cannot pass DEPTH.
        if (!valid[w_address]) begin
          used_count <= used_count + 1'b1;
        end
      end

      if (read_rq) begin
        if (same_addr && (BYPASS != 0)) begin
          read_data <= write_data;
        end else if (r_in_range && valid[r_address]) begin
          // With BYPASS == 0 a same-address write is still pending here,
          // so mem/valid give the pre-write view.
          read_data <= mem[r_address];
        end else begin
          read_data <= '0;
          read_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_param.sv
// -----------------------------------------------------------------------------
// Bench for mem_param. Three instances:
//   unit 0 : defaults (DEPTH 16, BYPASS 1)
//   unit 1 : BYPASS 0
//   unit 2 : DEPTH 10
// Each unit has its own inputs. Read stimulus pushes a hand-computed
// {read_data, read_err, used_count, full} into that unit's queue right after
// the accepting edge; a monitor on the falling edge pops and compares on
// every read_valid, and flags missing or unexpected responses.
// -----------------------------------------------------------------------------
module tb_mem_param;

  logic       clk;
  logic       rst_s      [3];
  logic       read_rq_s  [3];
  logic       write_rq_s [3];
  logic [3:0] w_addr_s   [3];
  logic [3:0] r_addr_s   [3];
  logic [4:0] wdata_s    [3];
  logic [4:0] rdata_s    [3];
  logic       rvalid_s   [3];
  logic       rerr_s     [3];
  logic [4:0] used_s     [3];
  logic       full_s     [3];

  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  logic [11:0] exp_q2[$];

  int vectors;
  int miscompares;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- DUTs ----------------
  mem_param u0 (
    .clk(clk), .rst(rst_s[0]), .read_rq(read_rq_s[0]), .write_rq(write_rq_s[0]),
    .w_address(w_addr_s[0]), .r_address(r_addr_s[0]), .write_data(wdata_s[0]),
    .read_data(rdata_s[0]), .read_valid(rvalid_s[0]), .read_err(rerr_s[0]),
    .used_count(used_s[0]), .full(full_s[0])
  );

  mem_param #(.BYPASS(0)) u1 (
    .clk(clk), .rst(rst_s[1]), .read_rq(read_rq_s[1]), .write_rq(write_rq_s[1]),
    .w_address(w_addr_s[1]), .r_address(r_addr_s[1]), .write_data(wdata_s[1]),
    .read_data(rdata_s[1]), .read_valid(rvalid_s[1]), .read_err(rerr_s[1]),
    .used_count(used_s[1]), .full(full_s[1])
  );

  mem_param #(.DEPTH(10)) u2 (
    .clk(clk), .rst(rst_s[2]), .read_rq(read_rq_s[2]), .write_rq(write_rq_s[2]),
    .w_address(w_addr_s[2]), .r_address(r_addr_s[2]), .write_data(wdata_s[2]),
    .read_data(rdata_s[2]), .read_valid(rvalid_s[2]), .read_err(rerr_s[2]),
    .used_count(used_s[2]), .full(full_s[2])
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int q_size(input int u);
    case (u)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [11:0] q_pop(input int u);
    case (u)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic q_push(input int u, input logic [11:0] e);
    case (u)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // ---------------- monitor ----------------
  task automatic mon_step(input int u);
    logic [11:0] e;
    if (rvalid_s[u] === 1'b1) begin
      if (q_size(u) == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL u%0d unexpected read_valid: got 1 expected 0 (t=%0t)", u, $time);
      end else begin
        e = q_pop(u);
        chk($sformatf("u%0d read {data,err,used,full}", u),
            {20'd0, rdata_s[u], rerr_s[u], used_s[u], full_s[u]}, {20'd0, e});
      end
    end else if (q_size(u) != 0) begin
      e = q_pop(u);
      vectors++;
      miscompares++;
      $display("FAIL u%0d missing read_valid: got 0 expected 1 (t=%0t)", u, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) mon_step(u);
  end

  // ---------------- driver tasks ----------------
  // One clock of stimulus on unit u. If a read is accepted (rd && !rs), the
  // expected response is queued right after the edge.
  task automatic op(input int u, input logic rs,
                    input logic wr, input logic [3:0] wa, input logic [4:0] wd,
                    input logic rd, input logic [3:0] ra,
                    input logic [4:0] ed, input logic ee, input logic [4:0] eu,
                    input logic ef);
    rst_s[u]      = rs;
    write_rq_s[u] = wr;
    w_addr_s[u]   = wa;
    wdata_s[u]    = wd;
    read_rq_s[u]  = rd;
    r_addr_s[u]   = ra;
    @(posedge clk);
    if (rd && !rs) q_push(u, {ed, ee, eu, ef});
    #1;
    rst_s[u]      = 1'b0;
    write_rq_s[u] = 1'b0;
    read_rq_s[u]  = 1'b0;
  endtask

  task automatic wr(input int u, input logic [3:0] a, input logic [4:0] d);
    op(u, 1'b0, 1'b1, a, d, 1'b0, 4'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic rd(input int u, input logic [3:0] a,
                    input logic [4:0] ed, input logic ee, input logic [4:0] eu, input logic ef);
    op(u, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1, a, ed, ee, eu, ef);
  endtask

  task automatic wrd(input int u, input logic [3:0] wa, input logic [4:0] wd, input logic [3:0] ra,
                     input logic [4:0] ed, input logic ee, input logic [4:0] eu, input logic ef);
    op(u, 1'b0, 1'b1, wa, wd, 1'b1, ra, ed, ee, eu, ef);
  endtask

  task automatic do_reset(input int u);
    op(u, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int u = 0; u < 3; u++) begin
      rst_s[u]      = 1'b1;
      read_rq_s[u]  = 1'b0;
      write_rq_s[u] = 1'b0;
      w_addr_s[u]   = '0;
      r_addr_s[u]   = '0;
      wdata_s[u]    = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) rst_s[u] = 1'b0;

    // Reset state of unit 0.
    chk("u0 reset read_data",  {31'd0, 1'b0} | rdata_s[0], 32'd0);
    chk("u0 reset read_valid", rvalid_s[0], 32'd0);
    chk("u0 reset read_err",   rerr_s[0],   32'd0);
    chk("u0 reset used_count", used_s[0],   32'd0);
    chk("u0 reset full",       full_s[0],   32'd0);

    // Unit 0: read of an unwritten entry.
    rd(0, 4'd7, 5'h00, 1'b1, 5'd0, 1'b0);
    // Write then read back.
    wr(0, 4'd3, 5'h15);
    rd(0, 4'd3, 5'h15, 1'b0, 5'd1, 1'b0);
    // Same-address read/write with forwarding.
    wr(0, 4'd5, 5'h0A);
    chk("u0 used after 2 writes", used_s[0], 32'd2);
    wrd(0, 4'd5, 5'h1F, 4'd5, 5'h1F, 1'b0, 5'd2, 1'b0);
    rd(0, 4'd5, 5'h1F, 1'b0, 5'd2, 1'b0);
    // Independent write and read to different addresses.
    wrd(0, 4'd8, 5'h07, 4'd3, 5'h15, 1'b0, 5'd3, 1'b0);
    rd(0, 4'd8, 5'h07, 1'b0, 5'd3, 1'b0);
    // read_data holds with no read.
    idle(2);
    chk("u0 read_data hold", rdata_s[0], 32'h07);
    rd(0, 4'd9, 5'h00, 1'b1, 5'd3, 1'b0);

    // Unit 0: fill all 16 entries from reset, then rewrite entry 0.
    do_reset(0);
    chk("u0 used after reset", used_s[0], 32'd0);
    for (int i = 0; i < 15; i++) wr(0, 4'(i), 5'(i + 1));
    chk("u0 used after 15", used_s[0], 32'd15);
    chk("u0 full after 15", full_s[0], 32'd0);
    wr(0, 4'd15, 5'h10);
    chk("u0 used after 16", used_s[0], 32'd16);
    chk("u0 full after 16", full_s[0], 32'd1);
    wr(0, 4'd0, 5'h1E);
    chk("u0 used after rewrite", used_s[0], 32'd16);
    chk("u0 full after rewrite", full_s[0], 32'd1);
    rd(0, 4'd0, 5'h1E, 1'b0, 5'd16, 1'b1);
    rd(0, 4'd15, 5'h10, 1'b0, 5'd16, 1'b1);

    // Unit 0: reset colliding with read and write.
    do_reset(0);
    for (int i = 0; i < 4; i++) wr(0, 4'(i), 5'(i + 1));
    chk("u0 used after fill 4", used_s[0], 32'd4);
    rd(0, 4'd2, 5'h03, 1'b0, 5'd4, 1'b0);
    op(0, 1'b1, 1'b1, 4'd9, 5'h11, 1'b1, 4'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("u0 used after rst+wr",      used_s[0],   32'd0);
    chk("u0 read_valid after rst+rd", rvalid_s[0], 32'd0);
    chk("u0 read_data after rst",    rdata_s[0],  32'd0);
    rd(0, 4'd9, 5'h00, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) rd(0, 4'(i), 5'h00, 1'b1, 5'd0, 1'b0);

    // Unit 1 (no forwarding): same-address read returns pre-write view.
    wr(1, 4'd5, 5'h0A);
    wrd(1, 4'd5, 5'h1F, 4'd5, 5'h0A, 1'b0, 5'd1, 1'b0);
    rd(1, 4'd5, 5'h1F, 1'b0, 5'd1, 1'b0);
    wrd(1, 4'd6, 5'h03, 4'd6, 5'h00, 1'b1, 5'd2, 1'b0);
    rd(1, 4'd6, 5'h03, 1'b0, 5'd2, 1'b0);

    // Unit 2 (DEPTH 10): out-of-range accesses.
    wrd(2, 4'd12, 5'h11, 4'd12, 5'h00, 1'b1, 5'd0, 1'b0);
    chk("u2 used after oob write", used_s[2], 32'd0);
    wr(2, 4'd9, 5'h09);
    rd(2, 4'd9, 5'h09, 1'b0, 5'd1, 1'b0);
    wrd(2, 4'd10, 5'h1F, 4'd10, 5'h00, 1'b1, 5'd1, 1'b0);
    rd(2, 4'd15, 5'h00, 1'b1, 5'd1, 1'b0);
    chk("u2 used final", used_s[2], 32'd1);

    idle(3);
    for (int u = 0; u < 3; u++) begin
      if (q_size(u) != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL u%0d leftover expected: got %0d pending expected 0", u, q_size(u));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_param.md
MEM_PARAM -- requirements
Module: mem_param

Interface
REQ-001 Parameter DATA_WIDTH, default 5, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width in bits.
REQ-003 Parameter DEPTH, default 16, SHALL set the number of entries; legal range 2 to 2**ADDR_WIDTH.
REQ-004 Parameter BYPASS, default 1, SHALL select same-address write-to-read forwarding (1) or read-old-data (0).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 read_rq  input  1  SHALL request a read of r_address.
REQ-008 write_rq  input  1  SHALL request a write of write_data to w_address.
REQ-009 w_address  input  ADDR_WIDTH  SHALL be the write address.
REQ-010 r_address  input  ADDR_WIDTH  SHALL be the read address.
REQ-011 write_data  input  DATA_WIDTH  SHALL be the write word.
REQ-012 read_data  output  DATA_WIDTH  SHALL be the registered read word.
REQ-013 read_valid  output  1  SHALL be a one-cycle pulse marking read_data as updated.
REQ-014 read_err  output  1  SHALL be a one-cycle pulse marking a read of an unwritten or out-of-range entry.
REQ-015 used_count  output  ADDR_WIDTH+1  SHALL be the number of distinct entries written since reset.
REQ-016 full  output  1  SHALL be high when used_count equals DEPTH.

Function
REQ-017 Writes SHALL complete in one cycle: write_rq high at edge N stores write_data at w_address and sets that entry's valid bit.
REQ-018 Reads SHALL have a latency of one cycle: read_rq high at edge N drives read_data, read_valid=1 after edge N.
REQ-019 read_valid and read_err SHALL be low in every cycle without a read accepted at the previous edge.
REQ-020 read_data SHALL hold its last value when no read is accepted.
REQ-021 A read of an entry whose valid bit is clear SHALL return read_data=0, read_valid=1, read_err=1.
REQ-022 Any address >= DEPTH SHALL be out of range: the write is ignored with no state change, and the read behaves as in REQ-021.
REQ-023 For a simultaneous read and write to the same in-range address with BYPASS=1, read_data SHALL return the new write_data with read_err=0.
REQ-024 For a simultaneous read and write to the same in-range address with BYPASS=0, read_data SHALL return the stored value before the write, and read_err SHALL reflect the valid bit before the write.
REQ-025 Simultaneous read and write to different addresses SHALL both complete independently in the same cycle.
REQ-026 used_count SHALL increment by 1 only on a write to an in-range entry whose valid bit was clear.
REQ-027 Rewriting an already-valid entry SHALL leave used_count unchanged.
REQ-028 used_count SHALL never exceed DEPTH.
REQ-029 Writes SHALL still be accepted when full is high; full SHALL only indicate occupancy and SHALL not block writes.

Reset
REQ-030 With rst high at an edge, the block SHALL clear all valid bits and set read_data=0, read_valid=0, read_err=0, used_count=0 and full=0.
REQ-031 rst SHALL take priority over read_rq and write_rq in the same cycle; a write in that cycle is discarded and a read in that cycle produces no read_valid.
REQ-032 Storage array contents need not be cleared by reset; REQ-021 guarantees reads of stale contents return 0.

Verification
REQ-033 Defaults; reset, then write 0x15 to address 3, read address 3 next cycle -> one cycle later read_data=0x15, read_valid=1, read_err=0, used_count=1.
REQ-034 After reset, read address 7 -> read_data=0, read_valid=1, read_err=1, used_count=0.
REQ-035 Address 5 holds 0x0A; in one cycle write 0x1F to address 5 and read address 5 -> BYPASS=1 gives read_data=0x1F; BYPASS=0 gives read_data=0x0A; used_count unchanged.
REQ-036 Write addresses 0..15 once each, then rewrite address 0 -> used_count=16 and full=1 after the 16th write, still 16 after the rewrite; read address 0 returns the rewritten value.
REQ-037 DEPTH=10: write 0x11 to address 12 and read address 12 -> used_count stays 0, read_err=1, read_data=0.
REQ-038 Fill 4 entries, assert rst together with write_rq to address 9 and read_rq -> next cycle used_count=0, read_valid=0; reads of address 9 and the 4 filled entries return read_err=1.
